// File: rtl/psg_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | psg_seq_pkg                                                                |
// | Shared state encoding and PSG bus-mode constants for the bus sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package psg_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_GAP   = 3'd2,
    S_DATA  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  // {BDIR,BC} encodings
  localparam logic [1:0] BUS_INACT = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_ADDR  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/psg_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | psg_rr_arbiter                                                             |
// | Two-way round-robin arbiter; the pointer flips away from each winner.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module psg_rr_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic r_ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr <= 1'b0;
    end else if (accept) begin
      r_ptr <= ~grant[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/psg_bus_sequencer.sv
// +----------------------------------------------------------------------------+
// | psg_bus_sequencer                                                          |
// | Arbitrates two requesters and sequences YM2149 latch/write/read phases.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module psg_bus_sequencer
  import psg_seq_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_data,
  input  logic       flush,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       psg_bdir,
  output logic       psg_bc,
  output logic [7:0] psg_di,
  input  logic [7:0] psg_do,
  output logic       busy
);

  localparam logic [3:0] C_HOLD_LAST = 4'(HOLD - 1);

  state_t      r_state;
  logic [1:0]  r_bus;
  logic [7:0]  r_di;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [3:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_id;
  logic        r_cache_valid;
  logic [3:0]  r_cache_addr;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [7:0]  r_rsp_data;

  logic [1:0]  w_grant;
  logic        w_idle;
  logic        w_accept;
  logic        w_id;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_hit;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & (|w_grant);

  psg_rr_arbiter u_arb (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    ({req1_valid, req0_valid}),
    .accept (w_accept),
    .grant  (w_grant)
  );

  assign w_id   = w_grant[1];
  assign w_we   = w_id ? req1_we   : req0_we;
  assign w_addr = w_id ? req1_addr : req0_addr;
  assign w_data = w_id ? req1_data : req0_data;
  // A flush in the handshake cycle must not let a stale latch skip the address phase
  assign w_hit  = r_cache_valid & (r_cache_addr == w_addr) & ~flush;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_bus         <= BUS_INACT;
      r_di          <= 8'h00;
      r_cnt         <= 4'h0;
      r_we          <= 1'b0;
      r_addr        <= 4'h0;
      r_data        <= 8'h00;
      r_id          <= 1'b0;
      r_cache_valid <= 1'b0;
      r_cache_addr  <= 4'h0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_data    <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= w_we;
            r_addr <= w_addr;
            r_data <= w_data;
            r_id   <= w_id;
            r_cnt  <= C_HOLD_LAST;
            if (w_hit) begin
              r_state <= S_DATA;
              r_bus   <= w_we ? BUS_WRITE : BUS_READ;
              r_di    <= w_we ? w_data : 8'h00;
            end else begin
              r_state <= S_ADDR;
              r_bus   <= BUS_ADDR;
              r_di    <= {4'h0, w_addr};
            end
          end
        end
        S_ADDR: begin
          if (r_cnt == 4'h0) begin
            r_state       <= S_GAP;
            r_bus         <= BUS_INACT;
            r_di          <= 8'h00;
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_addr;
          end else begin
            r_cnt <= r_cnt - 4'h1;
          end
        end
        S_GAP: begin
          r_state <= S_DATA;
          r_cnt   <= C_HOLD_LAST;
          r_bus   <= r_we ? BUS_WRITE : BUS_READ;
          r_di    <= r_we ? r_data : 8'h00;
        end
        S_DATA: begin
          if (r_cnt == 4'h0) begin
            if (!r_we) begin
              r_rsp_data <= psg_do;
            end
            r_state     <= S_RECOV;
            r_bus       <= BUS_INACT;
            r_di        <= 8'h00;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
          end else begin
            r_cnt <= r_cnt - 4'h1;
          end
        end
        S_RECOV: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_bus   <= BUS_INACT;
          r_di    <= 8'h00;
        end
      endcase
      // Placed last so an external PSG reset wins over a same-cycle latch update
      if (flush) begin
        r_cache_valid <= 1'b0;
      end
    end
  end

  assign req0_ready = w_idle & w_grant[0];
  assign req1_ready = w_idle & w_grant[1];
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign psg_bdir   = r_bus[1];
  assign psg_bc     = r_bus[0];
  assign psg_di     = r_di;
  assign busy       = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_psg_bus_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_psg_bus_sequencer                                                       |
// | Scoreboard bench with a behavioural PSG register file on the bus.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_psg_bus_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       req0_valid = 1'b0, req0_we = 1'b0;
  logic [3:0] req0_addr = 4'h0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_we = 1'b0;
  logic [3:0] req1_addr = 4'h0;
  logic [7:0] req1_data = 8'h00;
  logic       flush = 1'b0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy, psg_bdir, psg_bc;
  logic [7:0] rsp_data, psg_di, psg_do;

  logic       h3_valid = 1'b0;
  logic       h3_ready0, h3_ready1, h3_rsp_valid, h3_rsp_id, h3_busy, h3_bdir, h3_bc;
  logic [7:0] h3_rsp_data, h3_di;
  logic [7:0] h3_do = 8'h00;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    bit         id;
    bit         we;
    logic [7:0] rdata;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] psg_regs[16];
  logic [3:0] psg_latch;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  psg_bus_sequencer #(.HOLD(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .psg_bdir(psg_bdir), .psg_bc(psg_bc), .psg_di(psg_di), .psg_do(psg_do), .busy(busy)
  );

  psg_bus_sequencer #(.HOLD(3)) dut3 (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(h3_valid), .req0_ready(h3_ready0), .req0_we(1'b1),
    .req0_addr(4'h8), .req0_data(8'h1F),
    .req1_valid(1'b0), .req1_ready(h3_ready1), .req1_we(1'b0),
    .req1_addr(4'h0), .req1_data(8'h00),
    .flush(1'b0), .rsp_valid(h3_rsp_valid), .rsp_id(h3_rsp_id), .rsp_data(h3_rsp_data),
    .psg_bdir(h3_bdir), .psg_bc(h3_bc), .psg_di(h3_di), .psg_do(h3_do), .busy(h3_busy)
  );

  // Behavioural YM2149 register file; reset with the system
  always @(posedge CLK) begin
    if (RESET) begin
      psg_latch <= 4'h0;
      for (int i = 0; i < 16; i++) psg_regs[i] <= 8'h00;
    end else begin
      case ({psg_bdir, psg_bc})
        2'b11: if (psg_di[7:4] == 4'h0) psg_latch <= psg_di[3:0];
        2'b10: psg_regs[psg_latch] <= psg_di;
        default: ;
      endcase
    end
  end
  assign psg_do = ({psg_bdir, psg_bc} == 2'b01) ? psg_regs[psg_latch] : 8'hFF;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          if (!e.we) chk("rsp_data", 32'(rsp_data), 32'(e.rdata));
        end
      end
    end
  end

  task automatic access(input bit id, input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit hit, input logic [7:0] rd);
    int n;
    exp_t e;
    @(negedge CLK);
    if (id) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_data = d; end
    else    begin req0_valid = 1; req0_we = we; req0_addr = a; req0_data = d; end
    n = 0;
    #2;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge CLK); #2; n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 32'(n), 32'd0);
      req0_valid = 0; req1_valid = 0;
      return;
    end
    e.id = id; e.we = we; e.rdata = rd; e.due = cyc + (hit ? 2 : 4);
    exp_q.push_back(e);
    @(posedge CLK); #1;
    req0_valid = 0; req1_valid = 0;
    if (!hit) begin
      @(negedge CLK); chk("addr_phase", {psg_bdir, psg_bc, psg_di}, {2'b11, 4'h0, a});
      @(negedge CLK); chk("gap_phase", {psg_bdir, psg_bc}, 2'b00);
    end
    @(negedge CLK);
    chk("data_phase", {psg_bdir, psg_bc, psg_di}, we ? {2'b10, d} : {2'b01, 8'h00});
    @(negedge CLK); chk("recov_bus", {psg_bdir, psg_bc}, 2'b00);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30) begin
      @(negedge CLK); n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int order[$];
    int guard;
    int t;
    bit gid;
    logic [1:0] h3_bus_exp;
    logic [7:0] h3_di_exp;

    repeat (2) @(negedge CLK);
    chk("rst_bus", {psg_bdir, psg_bc, psg_di}, 10'h000);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 10'h000);
    chk("rst_busy_ready", {busy, req0_ready, req1_ready, h3_busy}, 4'h0);
    RESET = 0;
    @(negedge CLK);

    // 1: cold write R7, then 2: hit read from both requesters
    access(0, 1, 4'h7, 8'h38, 0, 8'h00);
    drain();
    chk("psg_r7", 32'(psg_regs[7]), 32'h38);
    access(0, 0, 4'h7, 8'h00, 1, 8'h38);
    access(1, 0, 4'h7, 8'h00, 1, 8'h38);
    drain();

    // 3: both requesters continuously valid
    @(negedge CLK);
    req0_valid = 1; req0_we = 1; req0_addr = 4'h0; req0_data = 8'hA0;
    req1_valid = 1; req1_we = 1; req1_addr = 4'h1; req1_data = 8'hB1;
    guard = 0;
    while (order.size() < 4 && guard < 100) begin
      #2;
      chk("ready_excl", {req0_ready & req1_ready, (req0_ready | req1_ready) & busy}, 2'b00);
      if (req0_ready | req1_ready) begin
        gid = req1_ready;
        exp_q.push_back('{id: gid, we: 1'b1, rdata: 8'h00, due: cyc + 4});
        order.push_back(int'(gid));
        if (order.size() == 4) begin
          @(posedge CLK); #1;
          req0_valid = 0; req1_valid = 0;
        end
      end
      if (order.size() < 4) @(negedge CLK);
      guard++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    drain();
    chk("psg_r0", 32'(psg_regs[0]), 32'hA0);
    chk("psg_r1", 32'(psg_regs[1]), 32'hB1);

    // 4: hit on R1, then flush forces the address phase again
    access(0, 0, 4'h1, 8'h00, 1, 8'hB1);
    @(negedge CLK); flush = 1;
    @(negedge CLK); flush = 0;
    access(0, 1, 4'h1, 8'h5A, 0, 8'h00);
    drain();
    chk("psg_r1_new", 32'(psg_regs[1]), 32'h5A);

    // 5: HOLD=3 instance writes R8
    @(negedge CLK);
    h3_valid = 1;
    guard = 0;
    #2;
    while (!h3_ready0 && guard < 20) begin @(negedge CLK); #2; guard++; end
    chk("h3_grant", 32'(h3_ready0), 32'd1);
    @(posedge CLK); #1;
    h3_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      h3_bus_exp = (k <= 3) ? 2'b11 : (k >= 5 && k <= 7) ? 2'b10 : 2'b00;
      h3_di_exp  = (k <= 3) ? 8'h08 : (k >= 5 && k <= 7) ? 8'h1F : h3_di;
      chk($sformatf("h3_step%0d", k), {h3_rsp_valid, h3_bdir, h3_bc, h3_di},
          {(k == 8), h3_bus_exp, h3_di_exp});
    end
    chk("h3_rsp_id", 32'(h3_rsp_id), 32'd0);

    // 6: reset during the data phase of a write
    @(negedge CLK);
    req0_valid = 1; req0_we = 1; req0_addr = 4'h2; req0_data = 8'h77;
    guard = 0;
    #2;
    while (!req0_ready && guard < 20) begin @(negedge CLK); #2; guard++; end
    chk("rst_case_grant", 32'(req0_ready), 32'd1);
    t = cyc;
    @(posedge CLK); #1;
    req0_valid = 0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_data", {psg_bdir, psg_bc, psg_di}, {2'b10, 8'h77});
    #1 RESET = 1;
    #1 chk("rst_async_bus", {psg_bdir, psg_bc, busy}, 3'b000);
    @(negedge CLK);
    RESET = 0;
    chk("rst_no_write", 32'(psg_regs[2]), 32'h00);
    access(0, 1, 4'h2, 8'h77, 0, 8'h00);
    drain();
    chk("psg_r2", 32'(psg_regs[2]), 32'h77);

    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
